// File: rtl/queue_push_arbiter.sv
// Round-robin push arbiter in front of a single bounded queue, with a single pop consumer.
// Tracks occupancy exactly and emits net +1/-1 pulses for a downstream counter.

module queue_push_arbiter_lane #(
  parameter int NUM_REQ = 4,
  parameter int IDX     = 0,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic            req,
  input  logic            gnt,
  input  logic [ID_W-1:0] pointer,
  output logic            elig,
  output logic            upper
);
  // A requester whose grant is visible this cycle sits out so it is not granted twice
  assign elig  = req & ~gnt;
  assign upper = elig & (ID_W'(IDX) >= pointer);
endmodule

module queue_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int QUEUE_SIZE = 16,
  parameter int CNT_W      = 32,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] push_req,
  output logic [NUM_REQ-1:0] push_gnt,
  output logic [ID_W-1:0]    grant_id,
  input  logic               pop_req,
  output logic               pop_gnt,
  output logic               increment,
  output logic               decrement,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam logic [CNT_W-1:0]   QSZ    = CNT_W'(QUEUE_SIZE);
  localparam logic [CNT_W-1:0]   QSZ_M1 = CNT_W'(QUEUE_SIZE - 1);
  localparam logic [CNT_W-1:0]   ONE_C  = CNT_W'(1);
  localparam logic [NUM_REQ-1:0] ONE_R  = NUM_REQ'(1);
  localparam logic [ID_W-1:0]    LAST   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_MID = 2'd1, S_FULL = 2'd2} state_t;

  state_t             state, next_state;
  logic [ID_W-1:0]    pointer, nxt_pointer;
  logic [NUM_REQ-1:0] elig, upper;
  logic [ID_W-1:0]    hi_idx, lo_idx, winner;
  logic               state_ok, pop_win, push_win;
  logic [NUM_REQ-1:0] nxt_gnt;
  logic [ID_W-1:0]    nxt_id;
  logic               nxt_inc, nxt_dec;
  logic [CNT_W-1:0]   nxt_count;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    queue_push_arbiter_lane #(.NUM_REQ(NUM_REQ), .IDX(g)) u_lane (
      .req    (push_req[g]),
      .gnt    (push_gnt[g]),
      .pointer(pointer),
      .elig   (elig[g]),
      .upper  (upper[g])
    );
  end

  // First eligible at/after pointer, else wrap to the first eligible overall
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (upper[i]) hi_idx = ID_W'(i);
      if (elig[i])  lo_idx = ID_W'(i);
    end
    winner = (|upper) ? hi_idx : lo_idx;
  end

  // An upset state encoding gets one recovery cycle with no grants
  assign state_ok = (state == S_EMPTY) || (state == S_MID) || (state == S_FULL);
  assign pop_win  = state_ok && pop_req && (count != '0) && !pop_gnt;
  assign push_win = state_ok && (|elig) && ((count < QSZ) || pop_win);

  always_ff @(posedge clock) begin
    if (reset) state <= S_EMPTY;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_EMPTY: if (push_win) next_state = S_MID;
      S_MID: begin
        if (push_win && !pop_win && count == QSZ_M1)   next_state = S_FULL;
        else if (pop_win && !push_win && count == ONE_C) next_state = S_EMPTY;
      end
      S_FULL:  if (pop_win && !push_win) next_state = S_MID;
      default: next_state = S_EMPTY;
    endcase
  end

  // Simultaneous push and pop cancel: the downstream counter cannot take both pulses
  always_comb begin
    nxt_inc     = push_win & ~pop_win;
    nxt_dec     = pop_win & ~push_win;
    nxt_gnt     = push_win ? (ONE_R << winner) : '0;
    nxt_id      = push_win ? winner : '0;
    nxt_pointer = pointer;
    if (push_win) nxt_pointer = (winner == LAST) ? '0 : winner + ID_W'(1);
    nxt_count   = count;
    if (nxt_inc)       nxt_count = count + ONE_C;
    else if (nxt_dec)  nxt_count = count - ONE_C;
    if (!state_ok) begin
      nxt_count   = '0;
      nxt_pointer = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      push_gnt  <= '0;
      grant_id  <= '0;
      pop_gnt   <= 1'b0;
      increment <= 1'b0;
      decrement <= 1'b0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      pointer   <= '0;
    end else begin
      push_gnt  <= nxt_gnt;
      grant_id  <= nxt_id;
      pop_gnt   <= pop_win;
      increment <= nxt_inc;
      decrement <= nxt_dec;
      count     <= nxt_count;
      full      <= (nxt_count == QSZ);
      empty     <= (nxt_count == '0);
      pointer   <= nxt_pointer;
    end
  end

endmodule

// File: tb/tb_queue_push_arbiter.sv
// Directed-vector bench for queue_push_arbiter: a driver queues hand-computed
// expectations, a monitor compares them one cycle later.

module tb_queue_push_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  push_req = '0;
  logic [3:0]  push_gnt;
  logic [1:0]  grant_id;
  logic        pop_req = 1'b0;
  logic        pop_gnt;
  logic        increment, decrement;
  logic [31:0] count;
  logic        full, empty;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic        pop;
    logic        inc;
    logic        dec;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  queue_push_arbiter #(.NUM_REQ(4), .QUEUE_SIZE(16), .CNT_W(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .push_req (push_req),
    .push_gnt (push_gnt),
    .grant_id (grant_id),
    .pop_req  (pop_req),
    .pop_gnt  (pop_gnt),
    .increment(increment),
    .decrement(decrement),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %0h expected %0h at %0t", tag, name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and queue the result expected after the next edge
  task automatic step(input logic rst, input logic [3:0] pr, input logic pp,
                      input logic [3:0] eg, input logic [1:0] eid, input logic ep,
                      input logic ei, input logic ed, input int ec, input string tag);
    exp_t e;
    @(negedge clock);
    reset    = rst;
    push_req = pr;
    pop_req  = pp;
    e.gnt = eg; e.id = eid; e.pop = ep; e.inc = ei; e.dec = ed; e.cnt = 32'(ec); e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("push_gnt",  e.tag, 32'(push_gnt), 32'(e.gnt));
        if (e.gnt != 4'b0) chk("grant_id", e.tag, 32'(grant_id), 32'(e.id));
        chk("pop_gnt",   e.tag, 32'(pop_gnt),   32'(e.pop));
        chk("increment", e.tag, 32'(increment), 32'(e.inc));
        chk("decrement", e.tag, 32'(decrement), 32'(e.dec));
        chk("count",     e.tag, count,          e.cnt);
        chk("full",      e.tag, 32'(full),      32'(e.cnt == 32'd16));
        chk("empty",     e.tag, 32'(empty),     32'(e.cnt == 32'd0));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [3:0] g;
    step(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, "reset0");
    step(1, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 0, "reset1");
    step(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0, "pop_empty0");
    step(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 0, "pop_empty1");

    // All four requesters held: grants rotate 0,1,2,3 one per cycle
    for (int k = 0; k < 16; k++) begin
      g = 4'b0001 << (k % 4);
      step(0, 4'b1111, 0, g, 2'(k % 4), 0, 1, 0, k + 1, "fill");
    end
    step(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 16, "full_block0");
    step(0, 4'b1111, 0, 4'b0000, 0, 0, 0, 0, 16, "full_block1");

    // Push into full queue allowed when a pop is granted in the same cycle
    step(0, 4'b0100, 1, 4'b0100, 2, 1, 0, 0, 16, "full_pushpop");
    step(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 16, "idle_full");

    // Held pop is granted only every other cycle
    step(0, 4'b0000, 1, 4'b0000, 0, 1, 0, 1, 15, "drain_a0");
    step(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 15, "drain_a1");
    step(0, 4'b0000, 1, 4'b0000, 0, 1, 0, 1, 14, "drain_a2");
    step(0, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 14, "drain_a3");

    // Requester 1 holds through its grant; pointer moves to 2 so 2 beats 0
    step(0, 4'b0010, 0, 4'b0010, 1, 0, 1, 0, 15, "rr_once");
    step(0, 4'b0111, 0, 4'b0100, 2, 0, 1, 0, 16, "rr_next");
    step(0, 4'b0011, 0, 4'b0000, 0, 0, 0, 0, 16, "rr_full");
    step(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 16, "rr_idle");

    for (int i = 0; i < 18; i++)
      step(0, 4'b0000, 1, 4'b0000, 0, (i % 2) == 0, 0, (i % 2) == 0, 16 - (i / 2 + 1), "drain_b");

    // Reset with grants in flight at count 7, then confirm pointer is back at 0
    step(0, 4'b0001, 1, 4'b0001, 0, 1, 0, 0, 7, "pre_reset");
    step(1, 4'b0010, 1, 4'b0000, 0, 0, 0, 0, 0, "mid_reset");
    step(0, 4'b1001, 1, 4'b0001, 0, 0, 1, 0, 1, "post_reset");
    step(0, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 1, "final_idle");

    repeat (3) @(posedge clock);
    #2;
    chk("scoreboard_drained", "end", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
